// File: rtl/inverse_park_pipe_pkg.sv
// Shared arithmetic helpers for the inverse Park pipeline: a wide signed
// accumulator type, the rounding constant and the saturate-to-width function.
package inv_park_pkg;

    // Wide enough for a (2*D_WIDTH+1)-bit sum plus rounding for D_WIDTH up to 64.
    localparam int unsigned ACC_W = 130;

    typedef logic signed [ACC_W-1:0] acc_t;

    function automatic acc_t round_const(input int unsigned q_bits);
        return acc_t'(1) <<< (q_bits - 1);
    endfunction

    function automatic acc_t sat_f(input acc_t v, input int unsigned w, output logic sat);
        acc_t hi;
        acc_t lo;
        hi    = (acc_t'(1) <<< (w - 1)) - acc_t'(1);
        lo    = -(acc_t'(1) <<< (w - 1));
        sat   = 1'b0;
        sat_f = v;
        if (v > hi) begin
            sat_f = hi;
            sat   = 1'b1;
        end else if (v < lo) begin
            sat_f = lo;
            sat   = 1'b1;
        end
    endfunction

endpackage

// File: rtl/inverse_park_pipe_sat_shift.sv
// Round (when INV_PARK_ROUND_EN is defined), arithmetic-shift and saturate one
// Park sum down to D_WIDTH bits. Purely combinational; the caller registers it.
module park_sat_shift
    import inv_park_pkg::*;
#(
    parameter int D_WIDTH = 32,
    parameter int Q_BITS  = 10
) (
    input  logic signed [2*D_WIDTH:0]  sum,
    output logic signed [D_WIDTH-1:0]  res,
    output logic                       sat
);

    acc_t wide;

    always_comb begin
        wide = acc_t'(sum);
`ifdef INV_PARK_ROUND_EN
        wide = wide + round_const(Q_BITS);
`endif
        wide = wide >>> Q_BITS;
        res  = D_WIDTH'(sat_f(wide, D_WIDTH, sat));
    end

endmodule

// File: rtl/inverse_park_pipe.sv
// Three-stage inverse Park transform with valid/ready backpressure and channel tag.
// Build option: INV_PARK_ROUND_EN selects round-half-up instead of floor before saturation.
module inverse_park_pipe
    import inv_park_pkg::*;
#(
    parameter  int D_WIDTH = 32,
    parameter  int Q_BITS  = 10,
    parameter  int N_CH    = 2,
    localparam int CH_W    = (N_CH > 1) ? $clog2(N_CH) : 1
) (
    input  logic                       clk,
    input  logic                       rstb,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [CH_W-1:0]            in_ch,
    input  logic signed [D_WIDTH-1:0]  D,
    input  logic signed [D_WIDTH-1:0]  Q,
    input  logic signed [D_WIDTH-1:0]  sin,
    input  logic signed [D_WIDTH-1:0]  cos,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [CH_W-1:0]            out_ch,
    output logic signed [D_WIDTH-1:0]  alpha,
    output logic signed [D_WIDTH-1:0]  beta,
    output logic [1:0]                 out_sat
);

    localparam int P_W = 2 * D_WIDTH;
    localparam int S_W = 2 * D_WIDTH + 1;

    logic adv;

    logic                  vld_p1;
    logic [CH_W-1:0]       ch_p1;
    logic signed [P_W-1:0] dc_p1;
    logic signed [P_W-1:0] qs_p1;
    logic signed [P_W-1:0] ds_p1;
    logic signed [P_W-1:0] qc_p1;

    logic                  vld_p2;
    logic [CH_W-1:0]       ch_p2;
    logic signed [S_W-1:0] asum_p2;
    logic signed [S_W-1:0] bsum_p2;

    logic signed [D_WIDTH-1:0] alpha_nxt;
    logic signed [D_WIDTH-1:0] beta_nxt;
    logic                      alpha_sat;
    logic                      beta_sat;

    // Whole pipe moves together; a stalled output freezes every stage, bubbles included.
    assign adv      = !out_valid || out_ready;
    assign in_ready = adv;

    // ---- S1: products ----
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            vld_p1 <= 1'b0;
        end else if (adv) begin
            vld_p1 <= in_valid;
        end
    end

    always_ff @(posedge clk) begin
        if (adv) begin
            ch_p1 <= in_ch;
            dc_p1 <= P_W'(D) * P_W'(cos);
            qs_p1 <= P_W'(Q) * P_W'(sin);
            ds_p1 <= P_W'(D) * P_W'(sin);
            qc_p1 <= P_W'(Q) * P_W'(cos);
        end
    end

    // ---- S2: sums ----
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            vld_p2 <= 1'b0;
        end else if (adv) begin
            vld_p2 <= vld_p1;
        end
    end

    always_ff @(posedge clk) begin
        if (adv) begin
            ch_p2   <= ch_p1;
            asum_p2 <= S_W'(dc_p1) - S_W'(qs_p1);
            bsum_p2 <= S_W'(ds_p1) + S_W'(qc_p1);
        end
    end

    // ---- S3: round/shift/saturate into the output registers ----
    park_sat_shift #(
        .D_WIDTH (D_WIDTH),
        .Q_BITS  (Q_BITS)
    ) u_alpha (
        .sum (asum_p2),
        .res (alpha_nxt),
        .sat (alpha_sat)
    );

    park_sat_shift #(
        .D_WIDTH (D_WIDTH),
        .Q_BITS  (Q_BITS)
    ) u_beta (
        .sum (bsum_p2),
        .res (beta_nxt),
        .sat (beta_sat)
    );

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            out_valid <= 1'b0;
            out_ch    <= '0;
            alpha     <= '0;
            beta      <= '0;
            out_sat   <= '0;
        end else if (adv) begin
            out_valid <= vld_p2;
            out_ch    <= ch_p2;
            alpha     <= alpha_nxt;
            beta      <= beta_nxt;
            out_sat   <= {beta_sat, alpha_sat};
        end
    end

endmodule

// File: tb/tb_inverse_park_pipe.sv
// Self-checking bench for inverse_park_pipe: directed vectors with literal
// expectations, randomized backpressure traffic against a queue model, mid-stream reset.
module tb_inverse_park_pipe;

    localparam int DW     = 16;
    localparam int QB     = 10;
    localparam int N_RAND = 200;

    typedef struct {
        logic                 ch;
        logic signed [DW-1:0] a;
        logic signed [DW-1:0] b;
        logic [1:0]           sat;
    } exp_t;

    logic                 clk = 1'b0;
    logic                 rstb;
    logic                 in_valid;
    logic                 in_ready;
    logic [0:0]           in_ch;
    logic signed [DW-1:0] d_in, q_in, s_in, c_in;
    logic                 out_valid;
    logic                 out_ready;
    logic [0:0]           out_ch;
    logic signed [DW-1:0] alpha, beta;
    logic [1:0]           out_sat;

    int n_cmp  = 0;
    int n_fail = 0;
    int n_in   = 0;
    int n_out  = 0;
    exp_t exp_q[$];

    logic                 held_v = 1'b0;
    logic signed [DW-1:0] held_a, held_b;
    logic                 held_ch;
    logic [1:0]           held_sat;

    inverse_park_pipe #(
        .D_WIDTH (DW),
        .Q_BITS  (QB),
        .N_CH    (2)
    ) dut (
        .clk       (clk),
        .rstb      (rstb),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_ch     (in_ch),
        .D         (d_in),
        .Q         (q_in),
        .sin       (s_in),
        .cos       (c_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_ch    (out_ch),
        .alpha     (alpha),
        .beta      (beta),
        .out_sat   (out_sat)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic signed [63:0] act, input logic signed [63:0] expv);
        n_cmp++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, expv);
        end
    endtask

    // Reference: exact integer Park math, then floor (or round) and clamp.
    function automatic exp_t model(input longint d, input longint q, input longint s,
                                   input longint c, input logic ch);
        longint sa, sb, hi, lo;
        exp_t r;
        sa = d * c - q * s;
        sb = d * s + q * c;
`ifdef INV_PARK_ROUND_EN
        sa = sa + (longint'(1) << (QB - 1));
        sb = sb + (longint'(1) << (QB - 1));
`endif
        sa = sa >>> QB;
        sb = sb >>> QB;
        hi = (longint'(1) << (DW - 1)) - 1;
        lo = -hi - 1;
        r.sat = 2'b00;
        if (sa > hi) begin sa = hi; r.sat[0] = 1'b1; end
        else if (sa < lo) begin sa = lo; r.sat[0] = 1'b1; end
        if (sb > hi) begin sb = hi; r.sat[1] = 1'b1; end
        else if (sb < lo) begin sb = lo; r.sat[1] = 1'b1; end
        r.ch = ch;
        r.a  = DW'(sa);
        r.b  = DW'(sb);
        return r;
    endfunction

    always @(negedge clk) begin
        if (!rstb) begin
            exp_q.delete();
            held_v = 1'b0;
        end else begin
            chk("in_ready", in_ready, !out_valid || out_ready);
            if (held_v) begin
                chk("stall_valid", out_valid, 1);
                chk("stall_alpha", alpha, held_a);
                chk("stall_beta", beta, held_b);
                chk("stall_ch", out_ch, held_ch);
                chk("stall_sat", out_sat, held_sat);
            end
            held_v   = out_valid && !out_ready;
            held_a   = alpha;
            held_b   = beta;
            held_ch  = out_ch;
            held_sat = out_sat;
            if (out_valid && out_ready) begin
                n_out++;
                if (exp_q.size() == 0) begin
                    chk("unexpected_out", 1, 0);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    chk("sb_alpha", alpha, e.a);
                    chk("sb_beta", beta, e.b);
                    chk("sb_ch", out_ch, e.ch);
                    chk("sb_sat", out_sat, e.sat);
                end
            end
            if (in_valid && in_ready) begin
                n_in++;
                exp_q.push_back(model(d_in, q_in, s_in, c_in, in_ch[0]));
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (5) step();
    endtask

    task automatic directed(input string nm, input logic signed [DW-1:0] dd, input logic signed [DW-1:0] qq,
                            input logic signed [DW-1:0] ss, input logic signed [DW-1:0] cc, input logic ch,
                            input int ea, input int eb, input int esat);
        exp_t m;
        m = model(dd, qq, ss, cc, ch);
        chk({nm, "_model_alpha"}, m.a, ea);
        chk({nm, "_model_beta"}, m.b, eb);
        chk({nm, "_model_sat"}, m.sat, esat);
        d_in = dd; q_in = qq; s_in = ss; c_in = cc; in_ch = ch;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        step();
        in_valid = 1'b0;
        step();
        chk({nm, "_early_valid"}, out_valid, 0);
        step();
        chk({nm, "_valid"}, out_valid, 1);
        chk({nm, "_alpha"}, alpha, ea);
        chk({nm, "_beta"}, beta, eb);
        chk({nm, "_ch"}, out_ch, ch);
        chk({nm, "_sat"}, out_sat, esat);
    endtask

    task automatic gen_sample(input int idx);
        in_ch = (idx < 8) ? 1'(idx) : 1'($urandom_range(0, 1));
        d_in  = DW'($urandom);
        q_in  = DW'($urandom);
        if ($urandom_range(0, 3) == 0) begin
            s_in = DW'($urandom);
            c_in = DW'($urandom);
        end else begin
            s_in = DW'(int'($urandom_range(0, 2048)) - 1024);
            c_in = DW'(int'($urandom_range(0, 2048)) - 1024);
        end
    endtask

    initial begin
        int   sent;
        int   cycles;
        int   stale;
        logic acc;
        rstb = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_ch = 1'b0;
        d_in = '0; q_in = '0; s_in = '0; c_in = '0;
        #1;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_alpha", alpha, 0);
        chk("rst_beta", beta, 0);
        chk("rst_out_ch", out_ch, 0);
        chk("rst_out_sat", out_sat, 0);
        repeat (3) step();
        rstb = 1'b1;
        chk("rst_in_ready", in_ready, 1);
        drain();

        directed("unity", 16'sd1024, 16'sd0, 16'sd0, 16'sd1024, 1'b1, 1024, 0, 0);
        drain();
        directed("rotation", 16'sd0, 16'sd2048, 16'sd1024, 16'sd0, 1'b0, -2048, 0, 0);
        drain();
        directed("saturation", 16'sd32767, -16'sd32768, 16'sd32767, 16'sd32767, 1'b1, 32767, -32, 1);
        drain();
`ifdef INV_PARK_ROUND_EN
        directed("rounding", 16'sd1, 16'sd0, 16'sd0, 16'sd512, 1'b0, 1, 0, 0);
`else
        directed("rounding", 16'sd1, 16'sd0, 16'sd0, 16'sd512, 1'b0, 0, 0, 0);
`endif
        drain();

        // Randomized traffic with random backpressure.
        sent   = 0;
        cycles = 0;
        gen_sample(0);
        while (sent < N_RAND && cycles < 5000) begin
            in_valid  = ($urandom_range(0, 9) < 8);
            out_ready = 1'($urandom_range(0, 1));
            @(negedge clk);
            acc = in_valid && in_ready;
            step();
            cycles++;
            if (acc) begin
                sent++;
                gen_sample(sent);
            end
        end
        chk("rand_sent", sent, N_RAND);
        drain();
        chk("rand_queue_empty", exp_q.size(), 0);
        chk("rand_in_out_count", n_out, n_in);

        // Reset with three samples in flight.
        out_ready = 1'b1;
        in_valid  = 1'b1;
        for (int i = 0; i < 3; i++) begin
            gen_sample(i);
            step();
        end
        in_valid = 1'b0;
        rstb = 1'b0;
        #1;
        chk("midrst_out_valid", out_valid, 0);
        chk("midrst_alpha", alpha, 0);
        chk("midrst_beta", beta, 0);
        chk("midrst_out_ch", out_ch, 0);
        chk("midrst_out_sat", out_sat, 0);
        out_ready = 1'b0;
        repeat (2) step();
        rstb = 1'b1;
        chk("midrst_in_ready", in_ready, 1);
        out_ready = 1'b1;
        stale = 0;
        repeat (5) begin
            step();
            if (out_valid) stale++;
        end
        chk("midrst_stale_outputs", stale, 0);
        directed("post_reset", 16'sd1024, 16'sd0, 16'sd0, 16'sd1024, 1'b1, 1024, 0, 0);
        drain();
        chk("final_queue_empty", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, got timeout, expected completion");
        $fatal(1, "timeout");
    end

endmodule
